// File: rtl/cordic_pkg.sv
// Shared constants, state type and arctangent table for the vectoring CORDIC.
// Angles are Q3.21 radians and vector components are Q1.23 fractions.
package cordic_pkg;

  // Widths of the datapath: 26-bit x/y so that negated full-scale inputs
  // and the CORDIC gain growth fit, 25-bit signed angle accumulator.
  localparam int unsigned DW = 26;
  localparam int unsigned ZW = 25;

  localparam logic [23:0] PI_Q21          = 24'h6487ED;
  localparam logic [23:0] TWO_PI_Q21      = 24'hC90FDB;
  localparam logic [23:0] PI_OVER_2_Q21   = 24'h3243F7;
  // 0.6072529 in Q1.23
  localparam logic [23:0] CORDIC_GAIN_INV = 24'h4DBA77;

  // round(atan(2^-i) * 2^21)
  localparam logic [23:0] ATAN_LUT [0:21] = '{
    24'd1647099, 24'd972340, 24'd513757, 24'd260791,
    24'd130902,  24'd65515,  24'd32765,  24'd16384,
    24'd8192,    24'd4096,   24'd2048,   24'd1024,
    24'd512,     24'd256,    24'd128,    24'd64,
    24'd32,      24'd16,     24'd8,      24'd4,
    24'd2,       24'd1
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  // Table lookup that returns zero for indices beyond the table.
  function automatic logic [23:0] atan_lut_at(input logic [4:0] idx);
    atan_lut_at = '0;
    for (int unsigned k = 0; k < 22; k++) begin
      if (idx == 5'(k)) atan_lut_at = ATAN_LUT[k];
    end
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring-mode CORDIC micro-rotation: drives y toward
// zero and accumulates the rotated angle into z.
module cordic_vec_stage
  import cordic_pkg::*;
(
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  input  logic signed [ZW-1:0] z_in,
  input  logic [4:0]           shift,
  input  logic [23:0]          atan,
  output logic signed [DW-1:0] x_out,
  output logic signed [DW-1:0] y_out,
  output logic signed [ZW-1:0] z_out
);

  logic signed [DW-1:0] x_sh;
  logic signed [DW-1:0] y_sh;
  logic signed [ZW-1:0] atan_s;

  // Rotate clockwise when y is non-negative, counter-clockwise otherwise.
  always_comb begin
    x_sh   = x_in >>> shift;
    y_sh   = y_in >>> shift;
    atan_s = $signed({1'b0, atan});
    if (!y_in[DW-1]) begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + atan_s;
    end else begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - atan_s;
    end
  end

endmodule

// File: rtl/atan2_cordic_q21.sv
// Iterative atan2 via vectoring CORDIC: one micro-rotation per clock,
// result angle in [0, 2*pi) as unsigned Q3.21.
// Optional feature: define ATAN2_MAG_OUT_EN to add the mag_out port
// (gain-corrected vector magnitude, Q1.23).
module atan2_cordic_q21
  import cordic_pkg::*;
#(
  parameter int unsigned ITER = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] sin_in,
  input  logic [23:0] cos_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] theta_out
`ifdef ATAN2_MAG_OUT_EN
  ,
  output logic [23:0] mag_out
`endif
);

  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  state_t state_q;
  state_t state_d;
  logic   accept;
  logic   last_step;

  logic [4:0]           cnt_q;
  logic signed [DW-1:0] x_q;
  logic signed [DW-1:0] y_q;
  logic signed [ZW-1:0] z_q;
  logic                 zero_q;

  logic signed [DW-1:0] x_ext;
  logic signed [DW-1:0] y_ext;
  logic signed [DW-1:0] x_pre;
  logic signed [DW-1:0] y_pre;
  logic signed [ZW-1:0] z_pre;

  logic signed [DW-1:0] x_nx;
  logic signed [DW-1:0] y_nx;
  logic signed [ZW-1:0] z_nx;
  logic [23:0]          atan_cur;

  logic [ZW-1:0] z_wrap;
  logic [23:0]   theta_c;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the accept / final-step strobes.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_ITER;
          accept  = 1'b1;
        end
      end
      S_ITER: begin
        if (cnt_q == LAST_CNT) begin
          state_d   = S_DONE;
          last_step = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pre-rotation by pi for left-half-plane inputs keeps the residual
  // angle inside the CORDIC convergence range.
  always_comb begin
    x_ext = {{2{cos_in[23]}}, cos_in};
    y_ext = {{2{sin_in[23]}}, sin_in};
    if (cos_in[23]) begin
      x_pre = -x_ext;
      y_pre = -y_ext;
      z_pre = $signed({1'b0, PI_Q21});
    end else begin
      x_pre = x_ext;
      y_pre = y_ext;
      z_pre = '0;
    end
  end

  assign atan_cur = atan_lut_at(cnt_q);

  cordic_vec_stage u_stage (
    .x_in  (x_q),
    .y_in  (y_q),
    .z_in  (z_q),
    .shift (cnt_q),
    .atan  (atan_cur),
    .x_out (x_nx),
    .y_out (y_nx),
    .z_out (z_nx)
  );

  // Fold negative angles into [0, 2*pi). A zero vector would otherwise
  // accumulate the full LUT sum, so it is flagged at accept and forced to 0.
  always_comb begin
    if (z_nx[ZW-1]) z_wrap = z_nx + ZW'(TWO_PI_Q21);
    else            z_wrap = z_nx;
    theta_c = z_wrap[23:0];
    if (zero_q || (theta_c == TWO_PI_Q21)) theta_c = '0;
  end

  // Iteration datapath: load on accept, one micro-rotation per ITER cycle,
  // capture the wrapped angle on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      zero_q    <= 1'b0;
      theta_out <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      x_q    <= x_pre;
      y_q    <= y_pre;
      z_q    <= z_pre;
      zero_q <= (cos_in == '0) && (sin_in == '0);
    end else if (state_q == S_ITER) begin
      cnt_q <= cnt_q + 5'd1;
      x_q   <= x_nx;
      y_q   <= y_nx;
      z_q   <= z_nx;
      if (last_step) theta_out <= theta_c;
    end
  end

`ifdef ATAN2_MAG_OUT_EN
  logic [DW-1:0] x_pos;
  logic [49:0]   mag_prod;
  logic [49:0]   mag_rnd;
  logic [23:0]   mag_c;

  // Gain-compensate the final x with round-to-nearest and saturation.
  always_comb begin
    x_pos    = x_nx[DW-1] ? '0 : x_nx;
    mag_prod = 50'(x_pos) * 50'(CORDIC_GAIN_INV);
    mag_rnd  = mag_prod + 50'(23'h400000);
    if (|mag_rnd[49:47]) mag_c = '1;
    else                 mag_c = mag_rnd[46:23];
  end

  // Magnitude register, updated together with theta_out.
  always_ff @(posedge clk) begin
    if (rst)            mag_out <= '0;
    else if (last_step) mag_out <= mag_c;
  end
`endif

endmodule

// File: tb/tb_atan2_cordic_q21.sv
// Self-checking bench for atan2_cordic_q21: directed vector table, stall and
// reset sequences, and random vectors against a real-valued atan2 model.
module tb_atan2_cordic_q21;

  localparam int unsigned ITER_TB = 22;
  localparam int TWO_PI_I = 13176795;
  localparam real PI_R = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] sin_in;
  logic [23:0] cos_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] theta_out;
`ifdef ATAN2_MAG_OUT_EN
  logic [23:0] mag_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [23:0] last_mag;

  atan2_cordic_q21 #(.ITER(ITER_TB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sin_in    (sin_in),
    .cos_in    (cos_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .theta_out (theta_out)
`ifdef ATAN2_MAG_OUT_EN
    ,
    .mag_out   (mag_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] c;
    logic [23:0] s;
    int          exp_theta;
    int          tol;
  } vec_t;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    int d;
    checks++;
    d = (act > exp) ? act - exp : exp - act;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h +/-%0d", name, act, exp, tol);
    end
  endtask

  // Angle comparison on the circle (0 and 2*pi-1 LSB are neighbours);
  // any value outside [0, 2*pi) fails regardless.
  task automatic chk_ang(input string name, input int act, input int exp, input int tol);
    int d;
    checks++;
    d = (act > exp) ? act - exp : exp - act;
    if (d > TWO_PI_I / 2) d = TWO_PI_I - d;
    if (d > tol || act >= TWO_PI_I) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h +/-%0d", name, act, exp, tol);
    end
  endtask

  function automatic int ref_theta(input logic [23:0] c, input logic [23:0] s);
    real a;
    int  q;
    if (c == 24'h0 && s == 24'h0) return 0;
    a = $atan2(real'(int'($signed(s))), real'(int'($signed(c))));
    if (a < 0.0) a = a + 2.0 * PI_R;
    q = int'($floor(a * 2097152.0 + 0.5));
    if (q >= TWO_PI_I) q = q - TWO_PI_I;
    return q;
  endfunction

  // Offer one sample, measure latency from the accepting edge, capture the
  // result and complete the output handshake.
  task automatic convert(input logic [23:0] c, input logic [23:0] s,
                         output logic [23:0] th, output int lat);
    int n;
    @(negedge clk);
    cos_in   = c;
    sin_in   = s;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    th = theta_out;
`ifdef ATAN2_MAG_OUT_EN
    last_mag = mag_out;
`else
    last_mag = '0;
`endif
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    logic [23:0] th;
    logic [23:0] th0;
    int          lat;
    int          bad_stable;
    int          bad_ready;
    int          bad_valid;
    int          seen_valid;

    vecs.push_back('{24'h7FFFFF, 24'h000000, 0,        4});
    vecs.push_back('{24'h000000, 24'h7FFFFF, 'h3243F7, 4});
    vecs.push_back('{24'h800000, 24'h000000, 'h6487EE, 4});
    vecs.push_back('{24'h000000, 24'h800000, 'h96CBE5, 4});
    vecs.push_back('{24'h000000, 24'h000000, 0,        0});
    vecs.push_back('{24'hC00000, 24'hFFFFFF, 'h6487EE, 4});
    vecs.push_back('{24'h5A8279, 24'h5A8279, 'h1921FB, 4});
    vecs.push_back('{24'h800000, 24'h800000, 'h7DA9E9, 4});
    vecs.push_back('{24'h400000, 24'hC00000, 'hAFEDE0, 4});

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cos_in    = '0;
    sin_in    = '0;
    last_mag  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_in_ready", int'(in_ready), 1);
    chk_eq("reset_out_valid", int'(out_valid), 0);
    chk_eq("reset_theta", int'(theta_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      convert(vecs[i].c, vecs[i].s, th, lat);
      chk_eq($sformatf("vec%0d_latency", i), lat, int'(ITER_TB));
      chk_ang($sformatf("vec%0d_theta", i), int'(th), vecs[i].exp_theta, vecs[i].tol);
`ifdef ATAN2_MAG_OUT_EN
      if (i == 6) chk_tol("vec6_mag", int'(last_mag), 'h7FFFFF, 8);
      if (i == 4) chk_eq("vec4_mag_zero", int'(last_mag), 0);
`endif
    end

    // Stall in DONE for 10 cycles with fresh in_valid traffic.
    @(negedge clk);
    cos_in = 24'h5A8279;
    sin_in = 24'h5A8279;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk_eq("stall_latency", lat, int'(ITER_TB));
    th0 = theta_out;
    bad_stable = 0;
    bad_ready = 0;
    bad_valid = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      cos_in = 24'h400000;
      sin_in = 24'h123456 + 24'(k);
      @(posedge clk);
      #1;
      if (theta_out != th0) bad_stable++;
      if (in_ready) bad_ready++;
      if (!out_valid) bad_valid++;
    end
    chk_eq("stall_theta_changes", bad_stable, 0);
    chk_eq("stall_in_ready_high", bad_ready, 0);
    chk_eq("stall_out_valid_low", bad_valid, 0);
    chk_ang("stall_theta", int'(th0), 'h1921FB, 4);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_eq("release_in_ready", int'(in_ready), 1);
    chk_eq("release_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk_eq("no_buffered_accept", int'(in_ready), 1);

    // Reset at iteration 10 aborts the conversion.
    @(negedge clk);
    cos_in = 24'h000000;
    sin_in = 24'h7FFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("midrst_out_valid", int'(out_valid), 0);
    chk_eq("midrst_in_ready", int'(in_ready), 1);
    chk_eq("midrst_theta", int'(theta_out), 0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < int'(ITER_TB) + 4; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    chk_eq("midrst_no_result", seen_valid, 0);
    convert(24'h800000, 24'h000000, th, lat);
    chk_eq("post_rst_latency", lat, int'(ITER_TB));
    chk_ang("post_rst_theta", int'(th), 'h6487EE, 4);

    // Random vectors with magnitude >= 0.5 against the real-valued model.
    for (int n = 0; n < 200; n++) begin
      logic [23:0] c;
      logic [23:0] s;
      int ci;
      int si;
      int tries;
      tries = 0;
      do begin
        c = 24'($urandom);
        s = 24'($urandom);
        ci = int'($signed(c));
        si = int'($signed(s));
        if (ci < 0) ci = -ci;
        if (si < 0) si = -si;
        tries++;
      end while (ci < 'h400000 && si < 'h400000 && tries < 50);
      if (ci < 'h400000 && si < 'h400000) begin
        c = 24'h400000;
      end
      convert(c, s, th, lat);
      chk_eq($sformatf("rand%0d_latency", n), lat, int'(ITER_TB));
      chk_ang($sformatf("rand%0d_theta c=%h s=%h", n, c, s), int'(th), ref_theta(c, s), 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atan2_cordic_q21.md
ATAN2_CORDIC_Q21 -- requirements
Module: atan2_cordic_q21

Interface
REQ-001 Parameter ITER, default 22: CORDIC micro-rotations per conversion (legal 16..22).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  sample pair offered.
REQ-005 in_ready  output  1  block can accept a sample pair.
REQ-006 sin_in  input  24  signed Q1.23 y component.
REQ-007 cos_in  input  24  signed Q1.23 x component.
REQ-008 out_valid  output  1  theta_out valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 theta_out  output  24  unsigned Q3.21 angle in [0, 2π).

Function
REQ-011 States: IDLE, ITER, DONE; in_ready=1 only in IDLE.
REQ-012 Accept on in_valid&in_ready edge; IDLE->ITER; iteration counter cleared.
REQ-013 Pre-rotation at accept: x,y sign-extended to 26 bits; if cos_in<0 then x=-x, y=-y, z=PI_Q21, else z=0.
REQ-014 ITER step i: y>=0 -> x+=y>>>i, y-=x>>>i, z+=ATAN_LUT[i]; y<0 -> opposite signs; arithmetic shifts, z 25-bit signed.
REQ-015 After step ITER-1 (ITER edges after accept): ITER->DONE; theta_out=z+TWO_PI_Q21 if z<0, else z; result equal to TWO_PI_Q21 forced to 0.
REQ-016 Latency: out_valid rises exactly ITER cycles after accepting edge; throughput one sample per ITER+1 cycles minimum.
REQ-017 DONE: out_valid=1, theta_out stable until out_ready=1; handshake edge -> IDLE, out_valid=0.
REQ-018 in_valid ignored outside IDLE; no input buffering.
REQ-019 sin_in=cos_in=0 -> theta_out=0.
REQ-020 Accuracy: |theta_out - exact| <= 4 LSB for input magnitude >= 0.25.
REQ-021 -full-scale inputs (24'h800000) handled without overflow via 26-bit datapath.

Reset
REQ-022 rst -> state IDLE, in_ready=1, out_valid=0, theta_out=0, counter=0.
REQ-023 rst mid-ITER or in DONE aborts conversion; no result emitted; next accept valid at first cycle after rst deasserts.

Configuration
REQ-024 Macro ATAN2_MAG_OUT_EN defined: extra port mag_out output 24 unsigned Q1.23 = round(x_final*CORDIC_GAIN_INV), saturated to 24'hFFFFFF, same valid/timing as theta_out, reset 0.
REQ-025 Macro undefined: no mag_out port, no gain multiplier; angle behaviour identical.

Structure
REQ-026 Shared package cordic_pkg: PI_Q21, TWO_PI_Q21, PI_OVER_2_Q21, CORDIC_GAIN_INV (Q1.23, 0.6072529), ATAN_LUT[0:21] Q3.21, state enum typedef.
REQ-027 One sub-module cordic_vec_stage: combinational single micro-rotation (x,y,z,shift,atan in -> x,y,z out).
REQ-028 FSM, counter, pre-rotation, wrap and handshake reside in top module.

Verification
REQ-029 cos=24'h7FFFFF, sin=0 -> theta_out=0 (±4), out_valid 22 cycles after accept.
REQ-030 cos=0, sin=24'h7FFFFF -> 0x3243F7; cos=24'h800000, sin=0 -> 0x6487EE; cos=0, sin=24'h800000 -> 0x96CBE5 (all ±4).
REQ-031 cos=sin=0 -> theta_out=0; cos=-0.5, sin=-tiny -> value near 0x6487EE, never >= TWO_PI_Q21.
REQ-032 out_ready low 10 cycles in DONE -> theta_out stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
REQ-033 rst pulse at iteration 10 -> out_valid stays 0, in_ready=1 after reset; subsequent conversion correct.
REQ-034 With ATAN2_MAG_OUT_EN: cos=sin=0x5A8279 -> mag_out ≈ 0x7FFFFF (±8), theta_out ≈ 0x1921FB (±4).
